// File: rtl/msi_dir_controller.sv
// MSI directory controller: arbitrates two private caches and serialises coherence transactions.
// Defining MSI_DIR_ACK_TIMEOUT_EN adds an ack timeout that forces completion and sets a sticky err.
module msi_dir_controller #(
  parameter int ADDR_W      = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        req,
  input  logic [1:0]        WriteRead0,
  input  logic [1:0]        WriteRead1,
  input  logic [1:0]        HitMiss0,
  input  logic [1:0]        HitMiss1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wb_ack,
  input  logic              inv_ack,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [2:0]        signal,
  output logic [1:0]        WriteBack,
  output logic [1:0]        invalidate,
  output logic [2:0]        newStateCache,
  output logic [2:0]        newStateDiretorio,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_M = 3'b011;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_WAIT, INV_WAIT, UPDATE} state_t;

  state_t state, next_state;

  logic              prio;
  logic              cur;
  logic [1:0]        op_wr;
  logic [1:0]        op_hm;
  logic [ADDR_W-1:0] op_addr;
  logic              done_q;
  logic [2:0]        nsc_q;
  logic [2:0]        nsd_q;
  logic [2:0]        dir_state [DEPTH];
  logic [1:0]        dir_sh    [DEPTH];

  logic       win;
  logic [2:0] entry_state;
  logic [1:0] entry_sh;
  logic [1:0] self_bit;
  logic [1:0] other_bit;
  logic       other_shares;
  logic       self_shares;
  logic       op_read;
  logic       op_write;
  logic       op_illegal;
  logic       op_hit;
  logic       wb_go;
  logic       inv_go;
  logic [2:0] sig_dec;
  logic [2:0] upd_state;
  logic [2:0] upd_nsc;
  logic [1:0] upd_sh;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // On a tie the priority pointer decides; otherwise the only requester wins.
  assign win          = (req == 2'b11) ? prio : req[1];
  assign entry_state  = dir_state[op_addr];
  assign entry_sh     = dir_sh[op_addr];
  assign self_bit     = cur ? 2'b10 : 2'b01;
  assign other_bit    = cur ? 2'b01 : 2'b10;
  assign other_shares = |(entry_sh & other_bit);
  assign self_shares  = |(entry_sh & self_bit);
  assign op_read      = (op_wr == 2'b00);
  assign op_write     = (op_wr == 2'b01);
  assign op_illegal   = op_wr[1];
  assign op_hit       = (op_hm == 2'b01);

`ifdef MSI_DIR_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  logic             tmo_wb;
  logic             tmo_inv;

  assign tmo_wb  = (state == WB_WAIT)  && !wb_ack  && (tmo_cnt == CNT_LAST);
  assign tmo_inv = (state == INV_WAIT) && !inv_ack && (tmo_cnt == CNT_LAST);
  assign wb_go   = wb_ack  || tmo_wb;
  assign inv_go  = inv_ack || tmo_inv;
  assign err     = err_q;

  // The counter restarts on every state change, so WB_WAIT and INV_WAIT each get a full budget.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (next_state != state)
        tmo_cnt <= '0;
      else if (state == WB_WAIT || state == INV_WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_wb || tmo_inv)
        err_q <= 1'b1;
    end
  end
`else
  assign wb_go  = wb_ack;
  assign inv_go = inv_ack;
  assign err    = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (|req) next_state = LOOKUP;
      LOOKUP: begin
        if (op_illegal)
          next_state = UPDATE;
        else if (entry_state == ST_M && other_shares)
          next_state = WB_WAIT;
        else if (op_write && entry_state == ST_S && other_shares)
          next_state = INV_WAIT;
        else
          next_state = UPDATE;
      end
      WB_WAIT:  if (wb_go) next_state = op_write ? INV_WAIT : UPDATE;
      INV_WAIT: if (inv_go) next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    sig_dec = 3'b000;
    if (op_read)
      sig_dec = op_hit ? 3'b010 : 3'b001;
    else if (op_write)
      sig_dec = op_hit ? 3'b100 : 3'b011;
  end

  // A read hit on a line the requester already owns keeps M; any other read downgrades to S.
  always_comb begin
    upd_state = entry_state;
    upd_sh    = entry_sh;
    upd_nsc   = nsc_q;
    if (op_write) begin
      upd_state = ST_M;
      upd_sh    = self_bit;
      upd_nsc   = ST_M;
    end else if (op_read) begin
      if (op_hit && entry_state == ST_M && self_shares) begin
        upd_state = ST_M;
        upd_nsc   = ST_M;
      end else begin
        upd_state = ST_S;
        upd_sh    = entry_sh | self_bit;
        upd_nsc   = ST_S;
      end
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    gnt        = 2'b00;
    signal     = 3'b000;
    WriteBack  = 2'b00;
    invalidate = 2'b00;
    if (state != IDLE) begin
      gnt    = self_bit;
      signal = sig_dec;
    end
    if (state == WB_WAIT)
      WriteBack = other_bit;
    if (state == INV_WAIT)
      invalidate = other_bit;
  end

  assign done              = done_q;
  assign newStateCache     = nsc_q;
  assign newStateDiretorio = nsd_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prio    <= 1'b0;
      cur     <= 1'b0;
      op_wr   <= 2'b00;
      op_hm   <= 2'b00;
      op_addr <= '0;
      done_q  <= 1'b0;
      nsc_q   <= 3'b000;
      nsd_q   <= 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
        dir_state[i] <= ST_I;
        dir_sh[i]    <= 2'b00;
      end
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && |req) begin
        cur     <= win;
        op_wr   <= win ? WriteRead1 : WriteRead0;
        op_hm   <= win ? HitMiss1 : HitMiss0;
        op_addr <= win ? addr1 : addr0;
      end
      if (state == UPDATE) begin
        done_q <= 1'b1;
        prio   <= ~cur;
        if (!op_illegal) begin
          dir_state[op_addr] <= upd_state;
          dir_sh[op_addr]    <= upd_sh;
          nsc_q              <= upd_nsc;
          nsd_q              <= upd_state;
        end
      end
    end
  end

endmodule

// File: tb/tb_msi_dir_controller.sv
// Directed, table-driven bench for msi_dir_controller with hand sequences for arbitration,
// mid-transaction reset and (when MSI_DIR_ACK_TIMEOUT_EN is defined) the ack timeout.
module tb_msi_dir_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] req;
  logic [1:0] WriteRead0, WriteRead1, HitMiss0, HitMiss1;
  logic [1:0] addr0, addr1;
  logic       wb_ack, inv_ack;
  logic [1:0] gnt;
  logic       busy;
  logic [2:0] signal;
  logic [1:0] WriteBack, invalidate;
  logic [2:0] newStateCache, newStateDiretorio;
  logic       done, err;

  int checks   = 0;
  int failures = 0;

  logic [2:0] obs_sig, obs_nsc, obs_nsd;
  logic [1:0] obs_wb, obs_inv;
  logic       obs_err;
  logic [1:0] grant_log [4];
  int         obs_done, obs_lat, n_grants;
  logic       ack_on;
  int         ack_delay;
  logic       stray_ack;

  typedef struct {
    logic       who;
    logic [1:0] wr;
    logic [1:0] hm;
    logic [1:0] addr;
    int         delay;
    logic       stray;
    logic [2:0] exp_sig;
    logic [1:0] exp_wb;
    logic [1:0] exp_inv;
    logic [2:0] exp_nsc;
    logic [2:0] exp_nsd;
    int         exp_lat;
  } vec_t;

  vec_t vecs [11];

  msi_dir_controller #(.ADDR_W(2), .TIMEOUT_CYC(16)) dut (
    .Clock(Clock), .Reset(Reset), .req(req),
    .WriteRead0(WriteRead0), .WriteRead1(WriteRead1),
    .HitMiss0(HitMiss0), .HitMiss1(HitMiss1),
    .addr0(addr0), .addr1(addr1),
    .wb_ack(wb_ack), .inv_ack(inv_ack),
    .gnt(gnt), .busy(busy), .signal(signal),
    .WriteBack(WriteBack), .invalidate(invalidate),
    .newStateCache(newStateCache), .newStateDiretorio(newStateDiretorio),
    .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cache(input logic who, input logic [1:0] wr, input logic [1:0] hm,
                             input logic [1:0] addr);
    if (who) begin
      WriteRead1 = wr; HitMiss1 = hm; addr1 = addr;
    end else begin
      WriteRead0 = wr; HitMiss0 = hm; addr0 = addr;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; req = 2'b00; wb_ack = 1'b0; inv_ack = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Plays the cache side: acks requests, drops req on done, records what was seen.
  task automatic run_cycles(input int max_cyc);
    logic [1:0] owner, prev_gnt;
    int         wb_seen, inv_seen;
    logic       finished;
    owner = 2'b00; prev_gnt = 2'b00; wb_seen = 0; inv_seen = 0; finished = 1'b0;
    obs_sig = 3'b000; obs_wb = 2'b00; obs_inv = 2'b00; obs_err = 1'b0;
    obs_nsc = 3'b000; obs_nsd = 3'b000; obs_done = 0; obs_lat = 0; n_grants = 0;
    for (int cyc = 1; cyc <= max_cyc && !finished; cyc++) begin
      tick();
      if (gnt != 2'b00) begin
        if (prev_gnt == 2'b00 && n_grants < 4) begin
          grant_log[n_grants] = gnt;
          n_grants++;
        end
        owner = gnt;
        if (signal != 3'b000) obs_sig = signal;
      end
      prev_gnt = gnt;
      obs_wb  = obs_wb | WriteBack;
      obs_inv = obs_inv | invalidate;
      if (WriteBack != 2'b00) wb_seen++;
      if (invalidate != 2'b00) inv_seen++;
      wb_ack  = stray_ack || (ack_on && WriteBack != 2'b00 && wb_seen > ack_delay);
      inv_ack = stray_ack || (ack_on && invalidate != 2'b00 && inv_seen > ack_delay);
      if (done) begin
        obs_done++;
        if (obs_done == 1) begin
          obs_lat = cyc; obs_nsc = newStateCache; obs_nsd = newStateDiretorio; obs_err = err;
        end
        req = req & ~owner;
      end
      if (req == 2'b00 && !busy && !done && obs_done > 0) finished = 1'b1;
    end
    wb_ack = 1'b0; inv_ack = 1'b0;
    check_val("run_completed", {31'd0, finished}, 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    ack_on = 1'b1; ack_delay = v.delay; stray_ack = v.stray;
    drive_cache(v.who, v.wr, v.hm, v.addr);
    req = v.who ? 2'b10 : 2'b01;
    run_cycles(60);
    stray_ack = 1'b0;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check_val($sformatf("v%0d_signal", idx), {29'd0, obs_sig}, {29'd0, v.exp_sig});
    check_val($sformatf("v%0d_writeback", idx), {30'd0, obs_wb}, {30'd0, v.exp_wb});
    check_val($sformatf("v%0d_invalidate", idx), {30'd0, obs_inv}, {30'd0, v.exp_inv});
    check_val($sformatf("v%0d_nsc", idx), {29'd0, obs_nsc}, {29'd0, v.exp_nsc});
    check_val($sformatf("v%0d_nsd", idx), {29'd0, obs_nsd}, {29'd0, v.exp_nsd});
    check_val($sformatf("v%0d_latency", idx), obs_lat, v.exp_lat);
    check_val($sformatf("v%0d_done_count", idx), obs_done, 1);
    check_val($sformatf("v%0d_grant", idx), {30'd0, grant_log[0]}, v.who ? 32'd2 : 32'd1);
    check_val($sformatf("v%0d_err", idx), {31'd0, obs_err}, 32'd0);
  endtask

  initial begin
    //         who  wr     hm     addr delay stray sig     wb     inv    nsc     nsd     lat
    vecs[0]  = '{1'b0, 2'b00, 2'b00, 2'd1, 0, 1'b0, 3'b001, 2'b00, 2'b00, 3'b010, 3'b010, 3};
    vecs[1]  = '{1'b1, 2'b01, 2'b00, 2'd1, 0, 1'b0, 3'b011, 2'b00, 2'b01, 3'b011, 3'b011, 4};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 2'd1, 0, 1'b0, 3'b001, 2'b10, 2'b00, 3'b010, 3'b010, 4};
    vecs[3]  = '{1'b1, 2'b01, 2'b01, 2'd1, 2, 1'b0, 3'b100, 2'b00, 2'b01, 3'b011, 3'b011, 6};
    vecs[4]  = '{1'b1, 2'b00, 2'b01, 2'd1, 0, 1'b1, 3'b010, 2'b00, 2'b00, 3'b011, 3'b011, 3};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 2'd1, 0, 1'b0, 3'b011, 2'b10, 2'b10, 3'b011, 3'b011, 5};
    vecs[6]  = '{1'b0, 2'b10, 2'b00, 2'd1, 0, 1'b0, 3'b000, 2'b00, 2'b00, 3'b011, 3'b011, 3};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'd1, 0, 1'b0, 3'b001, 2'b01, 2'b00, 3'b010, 3'b010, 4};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 2'd2, 0, 1'b0, 3'b001, 2'b00, 2'b00, 3'b010, 3'b010, 3};
    vecs[9]  = '{1'b1, 2'b01, 2'b11, 2'd0, 0, 1'b0, 3'b011, 2'b00, 2'b00, 3'b011, 3'b011, 3};
    vecs[10] = '{1'b0, 2'b00, 2'b01, 2'd0, 0, 1'b0, 3'b010, 2'b10, 2'b00, 3'b010, 3'b010, 4};

    WriteRead0 = 2'b00; WriteRead1 = 2'b00; HitMiss0 = 2'b00; HitMiss1 = 2'b00;
    addr0 = 2'd0; addr1 = 2'd0; ack_on = 1'b1; ack_delay = 0; stray_ack = 1'b0;

    Reset = 1'b1; req = 2'b00; wb_ack = 1'b0; inv_ack = 1'b0;
    tick();
    check_val("reset_gnt", {30'd0, gnt}, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_signal", {29'd0, signal}, 32'd0);
    check_val("reset_writeback", {30'd0, WriteBack}, 32'd0);
    check_val("reset_invalidate", {30'd0, invalidate}, 32'd0);
    check_val("reset_nsc", {29'd0, newStateCache}, 32'd0);
    check_val("reset_nsd", {29'd0, newStateDiretorio}, 32'd0);
    check_val("reset_done", {31'd0, done}, 32'd0);
    check_val("reset_err", {31'd0, err}, 32'd0);
    tick();
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
    end

    // Simultaneous requests twice in a row on one line; the second lookup sees the first commit.
    do_reset();
    ack_on = 1'b1; ack_delay = 0;
    drive_cache(1'b0, 2'b01, 2'b00, 2'd3);
    drive_cache(1'b1, 2'b00, 2'b00, 2'd3);
    req = 2'b11;
    run_cycles(60);
    check_val("rr1_first_gnt", {30'd0, grant_log[0]}, 32'd1);
    check_val("rr1_second_gnt", {30'd0, grant_log[1]}, 32'd2);
    check_val("rr1_done_count", obs_done, 2);
    check_val("rr1_writeback", {30'd0, obs_wb}, 32'd1);
    check_val("rr1_invalidate", {30'd0, obs_inv}, 32'd0);
    drive_cache(1'b0, 2'b00, 2'b00, 2'd3);
    drive_cache(1'b1, 2'b01, 2'b01, 2'd3);
    req = 2'b11;
    run_cycles(60);
    check_val("rr2_first_gnt", {30'd0, grant_log[0]}, 32'd1);
    check_val("rr2_second_gnt", {30'd0, grant_log[1]}, 32'd2);
    check_val("rr2_done_count", obs_done, 2);
    check_val("rr2_writeback", {30'd0, obs_wb}, 32'd0);
    check_val("rr2_invalidate", {30'd0, obs_inv}, 32'd1);
    check_val("rr2_nsd", {29'd0, newStateDiretorio}, 32'd3);

    // Reset while waiting for an invalidate ack aborts the transaction and clears the directory.
    do_reset();
    ack_on = 1'b1; ack_delay = 0;
    drive_cache(1'b0, 2'b00, 2'b00, 2'd1);
    req = 2'b01;
    run_cycles(30);
    check_val("rst_setup_latency", obs_lat, 3);
    drive_cache(1'b1, 2'b01, 2'b00, 2'd1);
    req = 2'b10;
    tick();
    tick();
    check_val("rst_in_inv_wait", {30'd0, invalidate}, 32'd1);
    Reset = 1'b1;
    tick();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_gnt", {30'd0, gnt}, 32'd0);
    check_val("rst_invalidate", {30'd0, invalidate}, 32'd0);
    check_val("rst_signal", {29'd0, signal}, 32'd0);
    check_val("rst_nsd", {29'd0, newStateDiretorio}, 32'd0);
    Reset = 1'b0; req = 2'b00;
    tick();
    check_val("rst_no_done", {31'd0, done}, 32'd0);
    drive_cache(1'b1, 2'b01, 2'b00, 2'd1);
    req = 2'b10;
    run_cycles(30);
    check_val("rst_line_is_i_inv", {30'd0, obs_inv}, 32'd0);
    check_val("rst_line_is_i_latency", obs_lat, 3);
    check_val("rst_line_is_i_nsd", {29'd0, obs_nsd}, 32'd3);

`ifdef MSI_DIR_ACK_TIMEOUT_EN
    // Never ack the invalidate: completion is forced after 16 wait cycles with err raised.
    do_reset();
    ack_on = 1'b1; ack_delay = 0;
    drive_cache(1'b0, 2'b00, 2'b00, 2'd1);
    req = 2'b01;
    run_cycles(30);
    ack_on = 1'b0;
    drive_cache(1'b1, 2'b01, 2'b00, 2'd1);
    req = 2'b10;
    run_cycles(60);
    check_val("tmo_invalidate", {30'd0, obs_inv}, 32'd1);
    check_val("tmo_latency", obs_lat, 19);
    check_val("tmo_err_at_done", {31'd0, obs_err}, 32'd1);
    check_val("tmo_nsd", {29'd0, obs_nsd}, 32'd3);
    tick();
    check_val("tmo_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    check_val("tmo_err_cleared", {31'd0, err}, 32'd0);
    ack_on = 1'b1;
`else
    check_val("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
